// File: rtl/selector_arbiter_ctrl_pkg.sv
// Shared types and constants for the lane-selector arbitration controller.
// Optional build macro: SELCTRL_FIXED_PRIO_EN (fixed-priority arbitration).
package selector_pkg;

    localparam int SEL_FIELD_W = 3;
    localparam int SEL_FIELDS  = 4;
    localparam int LANES       = 4;

    typedef logic [SEL_FIELDS*SEL_FIELD_W-1:0] sel_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/selector_arbiter_ctrl_if.sv
// Request/grant and selector-drive bundle between requesters and the controller.
// Optional build macro: SELCTRL_FIXED_PRIO_EN (no effect on this interface).
interface selector_arbiter_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int SELW  = 12,
    parameter int LANES = 4,
    parameter int LENW  = 4
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*SELW-1:0]  req_sel;
    logic [NREQ*LANES-1:0] req_lane;
    logic [NREQ*LENW-1:0]  req_len;
    logic [NREQ-1:0]       req_ready;
    logic [SELW-1:0]       sel_out;
    logic [LANES-1:0]      lane_en;
    logic                  busy;
    logic [2:0]            owner;
    logic                  done;

    modport master (
        output req_valid, req_sel, req_lane, req_len,
        input  req_ready, sel_out, lane_en, busy, owner, done
    );

    modport slave (
        input  req_valid, req_sel, req_lane, req_len,
        output req_ready, sel_out, lane_en, busy, owner, done
    );

endinterface

// File: rtl/selector_arbiter_ctrl_rr_pick.sv
// Combinational one-hot picker: round-robin after 'last', or lowest index.
// Optional build macro: SELCTRL_FIXED_PRIO_EN (reduces to a priority encoder).
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      last,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      idx
);

    logic [NREQ-1:0] pick;
    logic            found;

`ifdef SELCTRL_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;

    // Fixed priority: search the raw request vector from index 0
    always_comb begin
        pick = req;
    end
`else
    logic [NREQ-1:0] hi;

    // Prefer requesters above the last grantee, else wrap to the lowest
    always_comb begin
        hi = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi[i] = req[i] && (i > int'(last));
        end
        pick = (|hi) ? hi : req;
    end
`endif

    // Lowest set bit of the candidate vector becomes the grant
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && pick[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = 3'(i);
            end
        end
    end

endmodule

// File: rtl/selector_arbiter_ctrl.sv
// Grants one requester at a time and drives the lane selector for len+1 cycles.
// Optional build macro: SELCTRL_FIXED_PRIO_EN (fixed priority instead of RR).
module selector_arbiter_ctrl #(
    parameter int NREQ  = 4,
    parameter int SELW  = selector_pkg::SEL_FIELDS * selector_pkg::SEL_FIELD_W,
    parameter int LANES = selector_pkg::LANES,
    parameter int LENW  = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    selector_arbiter_ctrl_if.slave   bus
);

    import selector_pkg::*;

    state_t           state;
    state_t           nstate;
    logic [NREQ-1:0]  gnt;
    logic [2:0]       widx;
    logic [2:0]       last;
    logic             any;
    logic [SELW-1:0]  sel_w;
    logic [LANES-1:0] lane_w;
    logic [LENW-1:0]  len_w;
    logic [LENW-1:0]  cnt;
    logic [SELW-1:0]  sel_q;
    logic [LANES-1:0] lane_q;
    logic [2:0]       owner_q;
    logic             busy_q;
    logic             done_q;

    assign any = |bus.req_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (bus.req_valid),
        .last (last),
        .gnt  (gnt),
        .idx  (widx)
    );

    // One-hot mux of the winner's request fields
    always_comb begin
        sel_w  = '0;
        lane_w = '0;
        len_w  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_w  = sel_w  | bus.req_sel[i*SELW +: SELW];
                lane_w = lane_w | bus.req_lane[i*LANES +: LANES];
                len_w  = len_w  | bus.req_len[i*LENW +: LENW];
            end
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    // Next-state: accept in IDLE, count out HOLD, single GAP cycle
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (any) nstate = HOLD;
            HOLD:    if (cnt == '0) nstate = GAP;
            GAP:     nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

`ifdef SELCTRL_FIXED_PRIO_EN
    assign last = 3'(NREQ - 1);
`else
    // Round-robin pointer; reset makes requester 0 first in line
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            last <= 3'(NREQ - 1);
        end else if (state == IDLE && any) begin
            last <= widx;
        end
    end
`endif

    // Registered selector drive, hold counter and status flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sel_q   <= '0;
            lane_q  <= '0;
            cnt     <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        sel_q   <= sel_w;
                        lane_q  <= lane_w;
                        cnt     <= len_w;
                        owner_q <= widx;
                        busy_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        sel_q  <= '0;
                        lane_q <= '0;
                        done_q <= 1'b1;
                    end
                end
                GAP: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE) ? gnt : '0;
    assign bus.sel_out   = sel_q;
    assign bus.lane_en   = lane_q;
    assign bus.owner     = owner_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_selector_arbiter_ctrl.sv
// Directed bench for selector_arbiter_ctrl: handshake, hold timing, RR order, reset.
// Optional build macro: SELCTRL_FIXED_PRIO_EN (switches expected grant order).
module tb_selector_arbiter_ctrl;

    localparam int NREQ  = 4;
    localparam int SELW  = 12;
    localparam int LANES = 4;
    localparam int LENW  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    selector_arbiter_ctrl_if #(
        .NREQ(NREQ), .SELW(SELW), .LANES(LANES), .LENW(LENW)
    ) bus ();

    selector_arbiter_ctrl #(
        .NREQ(NREQ), .SELW(SELW), .LANES(LANES), .LENW(LENW)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int i, input logic [11:0] s,
                          input logic [3:0] l, input logic [3:0] n);
        bus.req_sel[i*SELW +: SELW]    = s;
        bus.req_lane[i*LANES +: LANES] = l;
        bus.req_len[i*LENW +: LENW]    = n;
    endtask

    initial begin
        int w;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_lane  = '0;
        bus.req_len   = '0;
        tick;
        tick;
        chk("rst_sel", bus.sel_out, 0);
        chk("rst_lane", bus.lane_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        tick;

        // single request from requester 2, len=2 -> 3 HOLD cycles
        setreq(2, 12'h688, 4'b0011, 4'd2);
        bus.req_valid = 4'b0100;
        #1;
        chk("single_ready", bus.req_ready, 4'b0100);
        tick;
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            chk("single_sel", bus.sel_out, 12'h688);
            chk("single_lane", bus.lane_en, 4'b0011);
            chk("single_owner", bus.owner, 2);
            chk("single_busy", bus.busy, 1);
            chk("single_done", bus.done, 0);
            chk("single_hold_ready", bus.req_ready, 0);
            tick;
        end
        chk("single_gap_done", bus.done, 1);
        chk("single_gap_lane", bus.lane_en, 0);
        chk("single_gap_sel", bus.sel_out, 0);
        chk("single_gap_busy", bus.busy, 1);
        tick;
        chk("single_idle_busy", bus.busy, 0);
        chk("single_idle_done", bus.done, 0);

        // requester 1 withdraws in 2nd HOLD cycle; hold still 6 cycles
        setreq(1, 12'hABC, 4'b1111, 4'd5);
        bus.req_valid = 4'b0010;
        #1;
        chk("wd_ready", bus.req_ready, 4'b0010);
        tick;
        for (int h = 0; h < 6; h++) begin
            if (h == 1) begin
                bus.req_valid = '0;
                #1;
            end
            chk("wd_lane", bus.lane_en, 4'b1111);
            chk("wd_busy", bus.busy, 1);
            chk("wd_done", bus.done, 0);
            tick;
        end
        chk("wd_gap_done", bus.done, 1);
        chk("wd_gap_lane", bus.lane_en, 0);
        tick;
        chk("wd_idle_busy", bus.busy, 0);

        // max length on requester 3, valid held: 16 HOLD cycles, no accept
        setreq(3, 12'h777, 4'b0101, 4'hF);
        bus.req_valid = 4'b1000;
        #1;
        chk("max_ready", bus.req_ready, 4'b1000);
        tick;
        for (int h = 0; h < 16; h++) begin
            chk("max_lane", bus.lane_en, 4'b0101);
            chk("max_sel", bus.sel_out, 12'h777);
            chk("max_hold_ready", bus.req_ready, 0);
            tick;
        end
        chk("max_gap_done", bus.done, 1);
        chk("max_gap_lane", bus.lane_en, 0);
        chk("max_gap_ready", bus.req_ready, 0);
        bus.req_valid = '0;
        tick;
        chk("max_idle_busy", bus.busy, 0);
        chk("max_idle_lane", bus.lane_en, 0);

        // async reset in the middle of a HOLD from requester 1
        setreq(1, 12'h123, 4'b1000, 4'd3);
        bus.req_valid = 4'b0010;
        #1;
        chk("mrst_ready", bus.req_ready, 4'b0010);
        tick;
        chk("mrst_busy_pre", bus.busy, 1);
        chk("mrst_owner_pre", bus.owner, 1);
        bus.req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_sel", bus.sel_out, 0);
        chk("mrst_lane", bus.lane_en, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_owner", bus.owner, 0);
        chk("mrst_done", bus.done, 0);
        tick;
        rst = 1'b0;
        tick;

        // all four valid, len=0: grants every 3 cycles
        for (int i = 0; i < NREQ; i++) begin
            setreq(i, 12'(12'h111 * (i + 1)), 4'(1 << i), 4'd0);
        end
        bus.req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
`ifdef SELCTRL_FIXED_PRIO_EN
            w = 0;
`else
            w = g % 4;
`endif
            chk("rr_ready", bus.req_ready, 1 << w);
            tick;
            chk("rr_owner", bus.owner, w);
            chk("rr_sel", bus.sel_out, 12'(12'h111 * (w + 1)));
            chk("rr_hold_ready", bus.req_ready, 0);
            tick;
            chk("rr_gap_done", bus.done, 1);
            chk("rr_gap_ready", bus.req_ready, 0);
            tick;
        end

        // requesters 1 and 3 held valid
        bus.req_valid = 4'b1010;
        #1;
        for (int g = 0; g < 2; g++) begin
`ifdef SELCTRL_FIXED_PRIO_EN
            w = 1;
`else
            w = (g == 0) ? 1 : 3;
`endif
            chk("pair_ready", bus.req_ready, 1 << w);
            tick;
            chk("pair_owner", bus.owner, w);
            tick;
            tick;
        end
        bus.req_valid = '0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/selector_arbiter_ctrl.md
Name: selector_arbiter_ctrl

Overview:
Arbitrates access to the shared 32-bit lane selector between NREQ requesters.
Each requester presents a select word (4 x 3-bit field selects), a 4-bit lane-enable mask and a hold length. The controller grants one requester at a time and drives the selector's select/lane-enable inputs for the requested number of cycles. It then inserts one turnaround cycle and re-arbitrates.
Sits directly in front of the selector datapath, replacing static tie-offs of its select inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
SELW, 12, select word width (4 fields x 3 bits)
LANES, 4, lane-enable width (drives selector SEL)
LENW, 4, hold-length field width

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
req_valid  input  NREQ  request pending, per requester
req_sel  input  NREQ*SELW  flattened select words, requester i at [i*SELW +: SELW]
req_lane  input  NREQ*LANES  flattened lane masks
req_len  input  NREQ*LENW  flattened hold lengths; hold = len+1 cycles
req_ready  output  NREQ  one-hot accept; handshake completes when valid & ready at a CLK edge
sel_out  output  SELW  select word to selector (registered)
lane_en  output  LANES  lane enables to selector SEL (registered)
busy  output  1  high in HOLD and GAP
owner  output  3  index of current grantee (valid while busy)
done  output  1  one-cycle pulse in the first GAP cycle

Behaviour:
- Reset (async, any state): state=IDLE; sel_out=0, lane_en=0, busy=0, owner=0, done=0, hold counter=0; RR pointer last=NREQ-1, so requester 0 has first priority.
- States: IDLE, HOLD, GAP.
- IDLE:
  - lane_en=0, sel_out holds 0.
  - If any req_valid, winner w = first set bit searching from last+1 with wraparound.
  - req_ready[w]=1 combinationally in the same cycle; all other ready bits 0.
  - At the edge: latch sel_out=req_sel[w], lane_en=req_lane[w], cnt=req_len[w], owner=w, last=w, busy=1; go to HOLD.
  - No valid: stay in IDLE, req_ready=0.
- req_ready is 0 in HOLD and GAP (no accept outside IDLE).
- HOLD:
  - Outputs stable.
  - cnt>0: cnt-=1.
  - cnt==0: go to GAP, clearing lane_en=0 and sel_out=0 at that edge and setting done=1.
  - Total HOLD duration = len+1 cycles (1..16).
- GAP:
  - Exactly one cycle; busy=1, done=1, lane_en=0.
  - Next edge: done=0, busy=0, go to IDLE.
- Grant-to-output latency: one cycle (accept edge -> outputs valid).
- Minimum request-to-request spacing: len+3 cycles (accept cycle + HOLD + GAP).
- Requester dropping req_valid during HOLD: ignored; the grant runs to completion.
- A requester may re-assert immediately but loses priority to the others under RR.
- lane mask 0 is legal: selector idles for the hold time, handshake is normal.
- Out-of-range field selects (values 4..7) pass through unchanged; the selector defines their effect.
- NREQ < 8: owner upper bits read 0.

Optional Feature:
Macro SELCTRL_FIXED_PRIO_EN.
- Defined: fixed priority, lowest asserted index always wins; RR pointer not implemented.
- Undefined (default): round-robin as above.

Decomposition:
- Package selector_pkg:
  - state enum {IDLE, HOLD, GAP}
  - SEL_FIELD_W=3, SEL_FIELDS=4, LANES=4 constants
  - typedef for the select word
- Sub-module rr_pick: combinational round-robin one-hot picker.
  - Inputs: req vector, last index.
  - Outputs: one-hot grant, encoded index.
  - Under SELCTRL_FIXED_PRIO_EN it reduces to a priority encoder.

Test Plan:
- Reset: assert RESET mid-HOLD -> all outputs 0 immediately (async); after release, the first grant with req_valid=4'b1111 goes to requester 0.
- Single request:
  - Stimulus: req_valid[2]=1, sel=12'h688, lane=4'b0011, len=2.
  - Response: req_ready[2] high 1 cycle; next 3 cycles sel_out=12'h688, lane_en=4'b0011, owner=2; then 1 GAP cycle with done=1, lane_en=0; then IDLE.
- Round-robin: all four valid continuously, len=0 -> grant order 0,1,2,3,0; each grant spaced exactly 3 cycles apart.
- Fixed-priority build (SELCTRL_FIXED_PRIO_EN): req_valid=4'b1010 held -> requester 1 granted every time; requester 3 is starved.
- Withdraw during HOLD: req_valid[1] dropped in the 2nd HOLD cycle with len=5 -> hold still lasts 6 cycles, then done pulses.
- Max length: len=4'hF -> HOLD lasts exactly 16 cycles; no counter wrap into an extra cycle; req_ready stays 0 throughout.
